cla_nibble_sequencer: RTL and testbench
=======================================

// Module: cla_nibble_sequencer
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor built on one shared 4-bit carry-lookahead slice.
//  - Accepts one operand pair per transaction on a valid/ready handshake.
//  - Processes one nibble per clock, LSB nibble first, chaining the carry through a register.
//  - Returns sum, carry-out and signed overflow on a valid/ready output handshake.
//  - Area-lean alternative to a full-width CLA, used where throughput of ~1 op per NIB+2 cycles suffices.
// PARAMETERS
//  WIDTH  16  operand width; must be a multiple of 4 and >= 8 (elaboration error otherwise)
//  NIB    WIDTH/4  derived localparam: nibble count = RUN cycles per op
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  reset_n    in   1      synchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in; ignored when sub=1
//  sub        in   1      0: a+b+cin   1: a-b (a+~b+1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB; for sub, 1 means no borrow (a>=b unsigned)
//  ovf        out  1      signed overflow = carry into MSB XOR cout
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (reset_n=0 at a rising edge):
//    - state=IDLE; sum=0, cout=0, ovf=0, out_valid=0.
//    - Operand, carry and index registers cleared.
//    - Any in-flight op is discarded, no result emitted; applies in every state.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    - IDLE: in_ready=1. in_valid at edge = accept:
//      - latch a, (sub ? ~b : b) and carry = (sub ? 1 : cin); idx=0; go to RUN.
//    - RUN: in_ready=0. Each edge writes slice sum into sum[4*idx+:4] and updates carry register.
//      - idx++; ovf captured on idx==NIB-1.
//      - After the edge with idx==NIB-1, go to DONE.
//    - DONE: out_valid=1; sum/cout/ovf held stable while out_ready=0.
//      - Edge with out_ready=1: go to IDLE, out_valid=0; sum/cout/ovf keep last values.
//  - Latency: accept edge = edge 0; out_valid=1 after edge NIB (WIDTH=16: 4 edges).
//  - Throughput: next accept is possible at edge NIB+2 at the earliest, given out_ready held 1.
//  - in_valid while in_ready=0 is ignored, never queued.
//    - a/b/cin/sub are sampled only at the accept edge; changes mid-op have no effect.
//  - Sum bits not yet written in RUN keep their previous-op values; only final values are valid.
//  - Arithmetic: per-slice P=a^b, G=a&b, lookahead carries, sum=P^C, cout=G3|P3&C3.
//    - Result wraps modulo 2^WIDTH; no saturation.
// STRUCTURE
//  - Shared package cla_pkg:
//    - state enum {IDLE, RUN, DONE}
//    - NIB_W = 4
//    - clog2 helper for idx width
//  - One sub-module cla4_slice (combinational):
//    - in: a[3:0], b[3:0], ci
//    - out: s[3:0], co, c3 (carry into bit 3, used for ovf)
//    - instantiated once and muxed by idx
//  - Top holds FSM, idx counter, carry register, operand and result registers.
// TESTING (WIDTH=16)
//  - a=16'h1234, b=16'h4321, cin=0, sub=0 -> out_valid after 4 edges.
//    - sum=16'h5555, cout=0, ovf=0.
//  - a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0 (full ripple across all nibbles).
//  - a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1.
//    - a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0.
//  - Hold out_ready=0 for 10 cycles in DONE:
//    - outputs stable, in_ready=0, in_valid pulses ignored.
//    - Then release: next accept at earliest legal edge.
//  - Drop reset_n for one edge mid-RUN (idx=2):
//    - next cycle IDLE, all outputs 0, out_valid never rises for that op.
//    - A following op completes correctly.
//  - Random back-to-back ops with random out_ready stalls (1000 ops):
//    - compare sum/cout/ovf against a behavioural model.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
//   state_t : sequencer FSM states
//   NIB_W   : width of the shared lookahead slice
//   clog2   : index width helper (never returns less than 1)
package cla_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIB_W = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result handshake bundle for cla_nibble_sequencer.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : adder side (drives in_ready, result, busy)
interface cla_nibble_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
//   a, b : nibble operands     ci : carry in
//   s    : nibble sum          co : carry out of bit 3
//   c3   : carry into bit 3 (lets the top derive signed overflow)
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] p, g, c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
        co   = g[3] | (p[3] & c[3]);
        c3   = c[3];
    end
endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor: one shared cla4_slice walks the
// operands one nibble per clock, LSB first, carry chained through a register.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : in_valid/in_ready + a/b/cin/sub operands,
//                  out_valid/out_ready + sum/cout/ovf result, busy
module cla_nibble_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cla_nibble_sequencer_if.slave  bus
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = clog2(NIB);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx;
    logic                      carry;
    logic [NIB-1:0][NIB_W-1:0] a_q, b_q, sum_q;
    logic                      cout_q, ovf_q;
    logic [NIB_W-1:0]          s_nib;
    logic                      co, c3;
    logic                      last;

    assign last = (idx == IDX_W'(NIB - 1));

    cla4_slice u_slice (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .ci (carry),
        .s  (s_nib),
        .co (co),
        .c3 (c3)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
    end

    // Datapath. Subtraction is folded in at accept time (invert b, force
    // carry-in), so RUN only ever adds. Result registers are untouched in
    // DONE/IDLE so the last result stays visible after hand-off.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q   <= bus.a;
                    b_q   <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.sub ? 1'b1 : bus.cin;
                    idx   <= '0;
                end
                RUN: begin
                    sum_q[idx] <= s_nib;
                    carry      <= co;
                    idx        <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout_q <= co;
                        ovf_q  <= c3 ^ co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
module tb_cla_nibble_sequencer;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, overflow judged by signed range.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, output logic [15:0] s, output logic co,
                         output logic ov);
        int ua, ub, sa, sbv, u, r;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            u  = ua - ub;
            co = (ua >= ub);
            r  = sa - sbv;
        end else begin
            u  = ua + ub + int'(ci);
            co = (u >= 65536);
            r  = sa + sbv + int'(ci);
        end
        s  = 16'(u);
        ov = (r > 32767) || (r < -32768);
    endtask

    // One transaction: accept, scramble inputs mid-op, measure latency,
    // stall the result for 'stall' cycles (pulsing in_valid), then take it.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, input int stall, input string tag);
        logic [15:0] es;
        logic        ec, eo;
        int          n;
        model(a, b, ci, sb, es, ec, eo);
        n = 0;
        while (!bus.in_ready && n < 50) begin step(); n++; end
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < 50) begin step(); n++; end
        chk({tag, ".latency"}, 32'(n), 32'(NIB));
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'(i % 2);
            chk({tag, ".stall_sum"},  32'(bus.sum),       32'(es));
            chk({tag, ".stall_v"},    32'(bus.out_valid), 32'd1);
            chk({tag, ".stall_rdy"},  32'(bus.in_ready),  32'd0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, ".sum"},  32'(bus.sum),       32'(es));
        chk({tag, ".cout"}, 32'(bus.cout),      32'(ec));
        chk({tag, ".ovf"},  32'(bus.ovf),       32'(eo));
        chk({tag, ".vld"},  32'(bus.out_valid), 32'd1);
        step();
        bus.out_ready = 1'b0;
        chk({tag, ".post_vld"},  32'(bus.out_valid), 32'd0);
        chk({tag, ".post_rdy"},  32'(bus.in_ready),  32'd1);
        chk({tag, ".post_busy"}, 32'(bus.busy),      32'd0);
        chk({tag, ".post_sum"},  32'(bus.sum),       32'(es));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst.sum",  32'(bus.sum),       32'd0);
        chk("rst.cout", 32'(bus.cout),      32'd0);
        chk("rst.ovf",  32'(bus.ovf),       32'd0);
        chk("rst.vld",  32'(bus.out_valid), 32'd0);
        chk("rst.rdy",  32'(bus.in_ready),  32'd1);
        chk("rst.busy", 32'(bus.busy),      32'd0);
        reset_n = 1'b1;
        step();

        // directed vectors
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "add_basic");
        chk("add_basic.exact", 32'(bus.sum), 32'h5555);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, "ripple");
        chk("ripple.exact", 32'({bus.cout, bus.sum}), 32'h10000);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "pos_ovf");
        chk("pos_ovf.exact", 32'({bus.ovf, bus.sum}), 32'h18000);
        do_op(16'h0003, 16'h0005, 1'b1, 1'b1, 0, "sub_borrow");
        chk("sub_borrow.exact", 32'({bus.cout, bus.sum}), 32'h0FFFE);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "neg_ovf");

        // long stall with in_valid pulses, then immediate next op
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 10, "stall10");
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, "after_stall");

        // reset in the middle of RUN (idx=2)
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mrst.busy", 32'(bus.busy),      32'd0);
        chk("mrst.rdy",  32'(bus.in_ready),  32'd1);
        chk("mrst.vld",  32'(bus.out_valid), 32'd0);
        chk("mrst.res",  32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
        for (int i = 0; i < NIB + 2; i++) begin
            chk("mrst.no_vld", 32'(bus.out_valid), 32'd0);
            step();
        end
        do_op(16'h1357, 16'hECA9, 1'b1, 1'b0, 1, "after_mrst");

        // random traffic with random result stalls
        for (int k = 0; k < 1000; k++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
